// File: rtl/spi_slave_rw.sv
// -----------------------------------------------------------------------------
// spi_slave_rw
//   SPI slave giving an external master read/write access to the MPPT control
//   and status register file. All four SPI modes, configurable word width,
//   R/nW command bit, optional address auto-increment and aborted-frame
//   detection. The SPI pins are asynchronous to clk and are synchronised here.
//
// Frame: one command word {R/nW, addr} followed by any number of data words.
//   Write frames strobe reg_we per completed word; read frames prefetch with
//   reg_re and shift the returned word out on MISO, MSB first.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_sck           SPI clock (asynchronous to clk)
//   spi_ss            slave select, active low
//   spi_mosi          master out
//   spi_miso          slave out (registered)
//   spi_miso_oe       MISO pad enable, high while the frame is selected
//   reg_addr          register address (WORD_W-1 bits)
//   reg_wdata         write data
//   reg_we            one-clk write strobe
//   reg_re            one-clk read strobe
//   reg_rdata         read data, valid the clk after reg_re
//   busy              frame in progress
//   frame_err         one-clk pulse when SS rises mid-word
// -----------------------------------------------------------------------------
module spi_slave_rw #(
  parameter int WORD_W   = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [WORD_W-2:0] reg_addr,
  output logic [WORD_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [WORD_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam int                ADDR_W   = WORD_W - 1;
  localparam int                CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic              CPOL_B   = (CPOL != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_e;

  state_e state_q, state_d;

  // Synchronisers: stage [1] is the synchronised value, stage [2] (sck, ss)
  // is its one-clk history used for edge detection.
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0] rx_q, rx_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [WORD_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              rdata_vld_q, rdata_vld_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;

  logic sck_s, sck_prev, ss_s, ss_prev, mosi_s;
  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ss_fall, last_sample;
  logic [WORD_W-1:0] word_in;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], spi_sck};
    ss_sync_d   = {ss_sync_q[1:0], spi_ss};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
  end

  assign sck_s    = sck_sync_q[1];
  assign sck_prev = sck_sync_q[2];
  assign ss_s     = ss_sync_q[1];
  assign ss_prev  = ss_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign lead_edge   = CPOL_B ? sck_fall : sck_rise;
  assign trail_edge  = CPOL_B ? sck_rise : sck_fall;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign ss_fall     = ss_prev & ~ss_s;

  // The word as it stands once the bit currently on MOSI is included.
  assign word_in     = {rx_q, mosi_s};
  assign last_sample = sample_edge && (bit_cnt_q == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ss_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (ss_s)             state_d = ST_IDLE;
        else if (last_sample) state_d = ST_DATA;
      end
      ST_DATA: if (ss_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output logic.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    rdata_vld_d = reg_re_q;   // register file answers the clk after reg_re
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    miso_d      = miso_q;

    if ((state_q != ST_IDLE) && ss_s) begin
      // Deselect: a partially shifted word is dropped and flagged.
      frame_err_d = (bit_cnt_q != '0);
      bit_cnt_d   = '0;
      busy_d      = 1'b0;
      miso_d      = 1'b0;
      rdata_vld_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ss_fall) begin
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            miso_d    = 1'b0;
          end
        end

        ST_CMD: begin
          if (sample_edge) begin
            rx_d = word_in[WORD_W-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              reg_addr_d = word_in[ADDR_W-1:0];
              rw_d       = word_in[WORD_W-1];
              reg_re_d   = word_in[WORD_W-1];
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        ST_DATA: begin
          // Writes advance the address one clk after the strobe so reg_we
          // is seen together with the address it belongs to.
          if (reg_we_q && (AUTO_INC != 0)) reg_addr_d = reg_addr_q + 1'b1;

          if (rw_q) begin
            // With CPHA=0 the MSB is driven at load time, so the shift edge
            // that trails the previous word's last sample (bit_cnt==0) is
            // skipped; otherwise it would discard the fresh MSB.
            if (shift_edge && ((CPHA != 0) || (bit_cnt_q != '0))) begin
              miso_d = tx_q[WORD_W-1];
              tx_d   = {tx_q[WORD_W-2:0], 1'b0};
            end
            if (rdata_vld_q) begin
              if (CPHA == 0) begin
                miso_d = reg_rdata[WORD_W-1];
                tx_d   = {reg_rdata[WORD_W-2:0], 1'b0};
              end else begin
                tx_d   = reg_rdata;
              end
            end
          end

          if (sample_edge) begin
            rx_d = word_in[WORD_W-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              if (rw_q) begin
                // Prefetch the next word; the final one of a frame is unused.
                reg_re_d = 1'b1;
                if (AUTO_INC != 0) reg_addr_d = reg_addr_q + 1'b1;
              end else begin
                reg_we_d    = 1'b1;
                reg_wdata_d = word_in;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is assigned with <= so every flop sees the
      // pre-edge value of every other flop.
      sck_sync_q  <= {3{CPOL_B}};
      // SS history resets low so a master already selected at reset release
      // does not look like a fresh frame start.
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rdata_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      rdata_vld_q <= rdata_vld_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_we      = reg_we_q;
  assign reg_re      = reg_re_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rw.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rw
//   Five spi_slave_rw instances (WORD_W=8): modes 0..3 with auto-increment and
//   mode 0 with the address held. One instance is selected per frame. A bench
//   register file answers reg_re/reg_we; a frame-level reference model predicts
//   the register transactions, the MISO words and frame_err.
// -----------------------------------------------------------------------------
module tb_spi_slave_rw;

  localparam int        N_DUT  = 5;
  localparam bit [4:0]  CPOL_V = 5'b01100;   // instance i uses bit i
  localparam bit [4:0]  CPHA_V = 5'b01010;
  localparam bit [4:0]  AUTO_V = 5'b01111;

  typedef struct packed {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_DUT-1:0] sck_pin, ss_n, miso, oe, we, re, busy, ferr;
  logic             mosi;
  logic [6:0]       addr  [N_DUT];
  logic [7:0]       wdata [N_DUT];
  logic [7:0]       rdata [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    spi_slave_rw #(
      .WORD_W  (8),
      .CPOL    (CPOL_V[g]),
      .CPHA    (CPHA_V[g]),
      .AUTO_INC(AUTO_V[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_sck    (sck_pin[g]),
      .spi_ss     (ss_n[g]),
      .spi_mosi   (mosi),
      .spi_miso   (miso[g]),
      .spi_miso_oe(oe[g]),
      .reg_addr   (addr[g]),
      .reg_wdata  (wdata[g]),
      .reg_we     (we[g]),
      .reg_re     (re[g]),
      .reg_rdata  (rdata[g]),
      .busy       (busy[g]),
      .frame_err  (ferr[g])
    );
  end

  // Register file shared by all instances, initialised to mem[a] = ~a.
  logic [7:0] mem [128];
  bit         mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 128; a++) mem[a] <= ~(8'(a));
      mem_init <= 1'b1;
    end else begin
      for (int g = 0; g < N_DUT; g++) begin
        if (re[g]) rdata[g] <= mem[addr[g]];
        if (we[g]) mem[addr[g]] <= wdata[g];
      end
    end
  end

  function automatic ev_t mk_ev(input logic wr, input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.wr = wr; e.addr = a; e.data = d;
    return e;
  endfunction

  // Monitor: record every strobe, count frame_err pulses and we/re overlaps.
  ev_t obs_q[$];
  int  ferr_cnt = 0;
  int  both_cnt = 0;

  always @(negedge clk) begin
    for (int g = 0; g < N_DUT; g++) begin
      if (we[g]) obs_q.push_back(mk_ev(1'b1, addr[g], wdata[g]));
      if (re[g]) obs_q.push_back(mk_ev(1'b0, addr[g], 8'h00));
      if (we[g] && re[g]) both_cnt++;
      if (ferr[g]) ferr_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input int g);
    check("rst_miso",  miso[g],  0);
    check("rst_oe",    oe[g],    0);
    check("rst_addr",  addr[g],  0);
    check("rst_wdata", wdata[g], 0);
    check("rst_we",    we[g],    0);
    check("rst_re",    re[g],    0);
    check("rst_busy",  busy[g],  0);
    check("rst_ferr",  ferr[g],  0);
  endtask

  // Frame stimulus and reference state.
  logic [7:0] tx_words [8];
  logic [7:0] rx_words [8];
  logic [7:0] ref_mem  [128];

  task automatic set_words(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    tx_words[0] = w0; tx_words[1] = w1; tx_words[2] = w2; tx_words[3] = w3;
  endtask

  // SPI master: nw full words then part extra bits of tx_words[nw].
  task automatic xfer(input int inst, input int nw, input int part, input bit do_rst);
    int   h;
    logic cpol, cpha;
    h    = $urandom_range(6, 9);
    cpol = CPOL_V[inst];
    cpha = CPHA_V[inst];
    ss_n[inst] = 1'b0;
    wait_clk(h + 4);
    check("busy_on", busy[inst], 1);
    check("oe_on",   oe[inst],   1);
    for (int w = 0; w < nw + ((part > 0) ? 1 : 0); w++) begin
      int         nb;
      logic [7:0] rb;
      nb = (w == nw) ? part : 8;
      rb = '0;
      for (int b = 0; b < nb; b++) begin
        if (!cpha) begin
          mosi = tx_words[w][7-b];
          wait_clk(h);
          rb[7-b] = miso[inst];
          sck_pin[inst] = ~cpol;
          wait_clk(h);
          sck_pin[inst] = cpol;
        end else begin
          sck_pin[inst] = ~cpol;
          mosi = tx_words[w][7-b];
          wait_clk(h);
          rb[7-b] = miso[inst];
          sck_pin[inst] = cpol;
          wait_clk(h);
        end
      end
      if (nb == 8) rx_words[w] = rb;
    end
    wait_clk(h);
    if (do_rst) begin
      rst_n = 1'b0;
      #1;
      check_reset(inst);
      ss_n[inst] = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
    end else begin
      ss_n[inst] = 1'b1;
      wait_clk(6);
    end
    check("busy_off", busy[inst], 0);
    check("oe_off",   oe[inst],   0);
    check("miso_idle", miso[inst], 0);
  endtask

  // Reference model: a frame is {R/nW, addr} then data words; writes store each
  // word at the running address, reads return ref_mem at the running address
  // and issue one read per address visited including the final prefetch.
  task automatic run_frame(input int inst, input int nw, input int part, input bit do_rst);
    ev_t        exp_q[$];
    logic [7:0] exp_miso [8];
    logic [6:0] a;
    logic       rw;
    bit         auto_inc;
    int         obs_base, ferr_base, both_base;
    auto_inc    = AUTO_V[inst];
    a           = tx_words[0][6:0];
    rw          = tx_words[0][7];
    exp_miso[0] = 8'h00;
    if (nw > 0 && rw) exp_q.push_back(mk_ev(1'b0, a, 8'h00));
    for (int i = 1; i < nw; i++) begin
      if (rw) begin
        exp_miso[i] = ref_mem[a];
        a = auto_inc ? a + 7'd1 : a;
        exp_q.push_back(mk_ev(1'b0, a, 8'h00));
      end else begin
        exp_miso[i] = 8'h00;
        exp_q.push_back(mk_ev(1'b1, a, tx_words[i]));
        ref_mem[a] = tx_words[i];
        a = auto_inc ? a + 7'd1 : a;
      end
    end
    obs_base  = obs_q.size();
    ferr_base = ferr_cnt;
    both_base = both_cnt;
    xfer(inst, nw, part, do_rst);
    check("ev_count", obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && (obs_base + i) < obs_q.size(); i++)
      check("event", obs_q[obs_base+i], exp_q[i]);
    for (int i = 0; i < nw; i++) check("miso_word", rx_words[i], exp_miso[i]);
    check("frame_err", ferr_cnt - ferr_base, (part > 0 && !do_rst) ? 1 : 0);
    check("we_re_overlap", both_cnt - both_base, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    ss_n    = '1;
    sck_pin = CPOL_V;
    mosi    = 1'b0;
    for (int a = 0; a < 128; a++) ref_mem[a] = ~(8'(a));
    wait_clk(5);
    for (int g = 0; g < N_DUT; g++) check_reset(g);
    rst_n = 1'b1;
    wait_clk(5);

    // Write and read frames in every mode.
    for (int m = 0; m < 4; m++) begin
      set_words(8'h05, 8'hA5, 8'h3C, 8'h00);
      run_frame(m, 3, 0, 1'b0);
      set_words(8'h90, 8'h00, 8'h00, 8'h00);
      run_frame(m, 3, 0, 1'b0);
      check("rd_byte0", rx_words[1], 8'hEF);
      check("rd_byte1", rx_words[2], 8'hEE);
    end

    // Address wrap with and without auto-increment.
    set_words(8'hFF, 8'h00, 8'h00, 8'h00);
    run_frame(0, 4, 0, 1'b0);
    set_words(8'hFF, 8'h00, 8'h00, 8'h00);
    run_frame(4, 4, 0, 1'b0);

    // Aborted word, then a normal frame reading back what was written.
    set_words(8'h02, 8'h55, 8'hF0, 8'h00);
    run_frame(0, 2, 4, 1'b0);
    set_words(8'h82, 8'h00, 8'h00, 8'h00);
    run_frame(0, 2, 0, 1'b0);
    check("abort_rdback", rx_words[1], 8'h55);

    // Reset in the middle of a data word, then a full frame.
    set_words(8'h20, 8'h11, 8'h22, 8'h00);
    run_frame(0, 2, 5, 1'b1);
    set_words(8'hA0, 8'h00, 8'h00, 8'h00);
    run_frame(0, 2, 0, 1'b0);
    check("rst_rdback", rx_words[1], 8'h11);

    // Randomised frames across all instances.
    for (int k = 0; k < 30; k++) begin
      int inst, nw, part;
      inst = $urandom_range(0, N_DUT - 1);
      nw   = $urandom_range(1, 4);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 8; i++) tx_words[i] = 8'($urandom);
      run_frame(inst, nw, part, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rw.md
# spi_slave_rw

Parametrised SPI slave for register read/write access to the MPPT control and status register file. It supports all four SPI modes (CPOL/CPHA), a configurable word width, a read/write command bit, optional address auto-increment and detection of aborted frames. It sits between the external SPI pins and the register file, and replaces the read-only mode-0 readout port.

## Interface
- WORD_W, default 8: bits per SPI word (4..16). The command word is [WORD_W-1] = R/nW and [WORD_W-2:0] = address.
- CPOL, default 0: idle level of SCK.
- CPHA, default 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- AUTO_INC, default 1: 1 = address increments after each data word; 0 = address is held.
- ADDR_W (local): WORD_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- spi_sck  in  1  SPI clock (asynchronous to clk)
- spi_ss  in  1  slave select, active low
- spi_mosi  in  1  master out
- spi_miso  out  1  slave out, registered
- spi_miso_oe  out  1  high while the frame is selected (pad tri-state control)
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  WORD_W  write data
- reg_we  out  1  one-clk write strobe
- reg_re  out  1  one-clk read strobe
- reg_rdata  in  WORD_W  read data; valid the clk after reg_re
- busy  out  1  frame in progress
- frame_err  out  1  one-clk pulse when SS rises with a partial word shifted

## Operation
- sck, ss and mosi each pass through a 2-flop synchroniser. Edges are detected from the synchronised sck.
- Edge roles:
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
  - Shift edge = the other edge.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
- States:
  - IDLE: on the synchronised ss falling edge, go to CMD, clear the bit counter and set busy.
  - CMD: shift WORD_W bits in, MSB first. On the last sample:
    - latch reg_addr = cmd[ADDR_W-1:0] and rw = cmd[WORD_W-1];
    - if rw=1, pulse reg_re;
    - go to DATA.
  - DATA, write (rw=0): on each completed word, reg_wdata = word and reg_we pulses at the current reg_addr. The address then increments if AUTO_INC=1.
  - DATA, read (rw=1):
    - the word captured from reg_rdata is shifted out MSB first;
    - on each completed word, increment the address (if AUTO_INC=1) and pulse reg_re to prefetch the next word;
    - MOSI is ignored.
  - Any state, synchronised ss high: return to IDLE on the next clk and clear busy.
    - If the bit counter is non-zero, pulse frame_err and discard the partial word: no reg_we.
- MISO:
  - changes only on shift edges, or at word load when CPHA=0 and no shift edge precedes the first sample;
  - the bit presented at sample n (0-based) of a read data word is rdata[WORD_W-1-n];
  - spi_miso = 0 in IDLE, in CMD and in write frames.
- Address arithmetic is modulo 2^ADDR_W: 0x7F+1 wraps to 0x00 for WORD_W=8.
- The final prefetch read at the end of a frame is expected and harmless.
- Reset values: spi_miso=0, spi_miso_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, frame_err=0, state=IDLE. Reset mid-frame abandons the frame with no strobe. The first frame after reset release starts at the next ss falling edge.
- A new ss falling edge while in CMD or DATA is impossible: ss must rise first.

## Timing
- Pin-to-edge detect: 2-3 clk.
- Let T be the clk in which the last sample edge of a word is detected.
  - reg_we/reg_re and reg_addr are asserted/valid at T+1.
  - reg_rdata is captured into the TX shifter at T+2.
- Requirement: f_clk ≥ 8 × f_sck and ss setup ≥ 4 clk before the first SCK edge. This guarantees the read MSB is on MISO before the next sample edge.
- reg_we and reg_re never assert in the same cycle. Each pulses at most once per word.
- The busy and spi_miso_oe falling edge is 1 clk after the synchronised ss rise.

## Test plan
- Mode 0, WORD_W=8, write frame 0x05, 0xA5, 0x3C → reg_we at addr 0x05 data 0xA5, then addr 0x06 data 0x3C. frame_err stays 0.
- Mode 0 read, cmd 0x90, model rdata = ~addr → MISO yields 0xEF, 0xEE. reg_re pulses at addrs 0x10, 0x11, 0x12.
- Repeat both frames in mode 1, mode 2 and mode 3 → identical register-side transactions and MISO bytes.
- Read cmd 0xFF, 3 data words, AUTO_INC=1 → addrs 0x7F, 0x00, 0x01. With AUTO_INC=0 → 0x7F three times.
- Write 0x02, 0x55, then 4 bits of 0xF0 and raise ss → one reg_we (0x02/0x55), one frame_err pulse, state returns to IDLE. The next frame decodes normally.
- Assert rst_n low mid-data-word → all outputs return to reset values immediately. No strobe is emitted. A following full frame succeeds.
